// File: rtl/mips_mc_ctrl_if.sv
// Instruction handshake, memory handshake and datapath control bundle for mips_mc_ctrl.
// The sequencer side is the master; the datapath/instruction source side is the slave.
interface mips_mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             instr_valid;
    logic [31:0]      instr;
    logic             instr_ready;
    logic             mem_ready;
    logic [4:0]       rd;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [15:0]      immediate;
    logic [1:0]       alu_control;
    logic             alu_src_imm;
    logic             imm_zero_ext;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_read;
    logic             mem_write;
    logic             illegal;
    logic             mem_timeout;
    logic             retired;
    logic [CNT_W-1:0] retire_count;

    modport master (
        input  instr_valid, instr, mem_ready,
        output instr_ready, rd, rs, rt, immediate, alu_control, alu_src_imm,
               imm_zero_ext, reg_write, mem_to_reg, mem_read, mem_write,
               illegal, mem_timeout, retired, retire_count
    );

    modport slave (
        output instr_valid, instr, mem_ready,
        input  instr_ready, rd, rs, rt, immediate, alu_control, alu_src_imm,
               imm_zero_ext, reg_write, mem_to_reg, mem_read, mem_write,
               illegal, mem_timeout, retired, retire_count
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multicycle sequencer for a MIPS subset: decodes one instruction at a time and steps the
// register-file/ALU/data-memory datapath through DECODE, EXEC, MEM and WB.
//
// state  | meaning
// IDLE   | waiting for an instruction, instr_ready high
// DECODE | fields registered; illegal pulse here for unsupported encodings
// EXEC   | ALU result settles
// MEM    | lw/sw access held until mem_ready or the timeout down-counter hits zero
// WB     | register write strobe (suppressed for rd==0) and retire pulse
module mips_mc_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    mips_mc_ctrl_if.master bus
);
    localparam int TMR_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t           state, state_nx;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] cnt;

    logic [4:0]  rd_q, rs_q, rt_q;
    logic [15:0] imm_q;
    logic [1:0]  alu_q;
    logic        src_imm_q, zext_q, legal_q, lw_q, sw_q;

    logic [4:0]  dec_rd;
    logic [1:0]  dec_alu;
    logic        dec_ok, dec_imm, dec_zext, dec_lw, dec_sw;

    logic instr_ready_c, illegal_c, timeout_c, retired_c;
    logic reg_write_c, mem_read_c, mem_write_c, accept;

    // Shift amount is not part of the supported subset.
    logic unused_shamt;
    assign unused_shamt = ^bus.instr[10:6];

    always_comb begin
        dec_ok   = 1'b1;
        dec_alu  = 2'b00;
        dec_imm  = 1'b1;
        dec_zext = 1'b0;
        dec_lw   = 1'b0;
        dec_sw   = 1'b0;
        dec_rd   = bus.instr[20:16];
        case (bus.instr[31:26])
            6'h00: begin
                dec_imm = 1'b0;
                dec_rd  = bus.instr[15:11];
                case (bus.instr[5:0])
                    6'h20:   dec_alu = 2'b00;
                    6'h22:   dec_alu = 2'b01;
                    6'h24:   dec_alu = 2'b10;
                    6'h25:   dec_alu = 2'b11;
                    default: dec_ok  = 1'b0;
                endcase
            end
            6'h08: dec_alu = 2'b00;
            6'h0C: begin
                dec_alu  = 2'b10;
                dec_zext = 1'b1;
            end
            6'h0D: begin
                dec_alu  = 2'b11;
                dec_zext = 1'b1;
            end
            6'h23:   dec_lw = 1'b1;
            6'h2B:   dec_sw = 1'b1;
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nx      = state;
        instr_ready_c = 1'b0;
        illegal_c     = 1'b0;
        timeout_c     = 1'b0;
        retired_c     = 1'b0;
        reg_write_c   = 1'b0;
        mem_read_c    = 1'b0;
        mem_write_c   = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready_c = 1'b1;
                if (bus.instr_valid) state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (legal_q) begin
                    state_nx = S_EXEC;
                end else begin
                    illegal_c = 1'b1;
                    state_nx  = S_IDLE;
                end
            end
            S_EXEC: state_nx = (lw_q || sw_q) ? S_MEM : S_WB;
            S_MEM: begin
                mem_read_c  = lw_q;
                mem_write_c = sw_q;
                // mem_ready in the final counted cycle still completes the access.
                if (bus.mem_ready) begin
                    if (sw_q) begin
                        retired_c = 1'b1;
                        state_nx  = S_IDLE;
                    end else begin
                        state_nx = S_WB;
                    end
                end else if (tmr == '0) begin
                    timeout_c = 1'b1;
                    state_nx  = S_IDLE;
                end
            end
            S_WB: begin
                reg_write_c = (rd_q != 5'd0);
                retired_c   = 1'b1;
                state_nx    = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign accept = instr_ready_c && bus.instr_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            tmr       <= '0;
            cnt       <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            imm_q     <= '0;
            alu_q     <= '0;
            src_imm_q <= 1'b0;
            zext_q    <= 1'b0;
            legal_q   <= 1'b0;
            lw_q      <= 1'b0;
            sw_q      <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                rd_q      <= dec_rd;
                rs_q      <= bus.instr[25:21];
                rt_q      <= bus.instr[20:16];
                imm_q     <= bus.instr[15:0];
                alu_q     <= dec_alu;
                src_imm_q <= dec_imm;
                zext_q    <= dec_zext;
                legal_q   <= dec_ok;
                lw_q      <= dec_ok && dec_lw;
                sw_q      <= dec_ok && dec_sw;
            end
            // Loaded in EXEC so the first MEM cycle sees MEM_TIMEOUT-1 remaining.
            if (state == S_EXEC) begin
                tmr <= TMR_W'(MEM_TIMEOUT - 1);
            end else if (state == S_MEM && tmr != '0) begin
                tmr <= tmr - TMR_W'(1);
            end
            if (retired_c) cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.instr_ready  = instr_ready_c;
    assign bus.rd           = rd_q;
    assign bus.rs           = rs_q;
    assign bus.rt           = rt_q;
    assign bus.immediate    = imm_q;
    assign bus.alu_control  = alu_q;
    assign bus.alu_src_imm  = src_imm_q;
    assign bus.imm_zero_ext = zext_q;
    assign bus.mem_to_reg   = lw_q;
    assign bus.reg_write    = reg_write_c;
    assign bus.mem_read     = mem_read_c;
    assign bus.mem_write    = mem_write_c;
    assign bus.illegal      = illegal_c;
    assign bus.mem_timeout  = timeout_c;
    assign bus.retired      = retired_c;
    assign bus.retire_count = cnt;
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: the driver pushes reference-model expectations,
// a negedge monitor pops one per illegal/mem_timeout/retired pulse and compares.
`timescale 1ns/1ps
module tb_mips_mc_ctrl;
    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 15;
    localparam int K_RETIRE    = 0;
    localparam int K_ILLEGAL   = 1;
    localparam int K_TIMEOUT   = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mips_mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mips_mc_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        int          kind;
        int          age;
        logic [35:0] fields;
        bit          check_fields;
        int          n_rw;
        int          n_mr;
        int          n_mw;
        int          cnt_after;
    } exp_t;

    exp_t sb[$];
    int   checks       = 0;
    int   errors       = 0;
    int   model_cnt    = 0;
    int   accepted_seq = 0;

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic check(input string name, input longint actual, input longint required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, actual, required);
        end
    endtask

    // d = MEM cycle (1-based) in which mem_ready arrives; outside 1..MEM_TIMEOUT means never.
    function automatic exp_t model(input logic [31:0] w, input int d);
        exp_t       e;
        int         op, fn, alu, mc;
        logic [4:0] dst;
        bit         legal, lw, sw, zext, src;
        op    = int'(w[31:26]);
        fn    = int'(w[5:0]);
        legal = 1; lw = 0; sw = 0; zext = 0; src = 1; alu = 0;
        dst   = w[20:16];
        if (op == 0) begin
            src = 0;
            dst = w[15:11];
            if (fn == 32) alu = 0;
            else if (fn == 34) alu = 1;
            else if (fn == 36) alu = 2;
            else if (fn == 37) alu = 3;
            else legal = 0;
        end else if (op == 8) alu = 0;
        else if (op == 12) begin alu = 2; zext = 1; end
        else if (op == 13) begin alu = 3; zext = 1; end
        else if (op == 35) lw = 1;
        else if (op == 43) sw = 1;
        else legal = 0;
        e.fields       = {dst, w[25:21], w[20:16], w[15:0], 2'(alu), src, zext, lw};
        e.check_fields = legal;
        e.n_rw = 0; e.n_mr = 0; e.n_mw = 0; e.cnt_after = 0;
        mc = (d >= 1 && d <= MEM_TIMEOUT) ? d : MEM_TIMEOUT;
        if (!legal) begin
            e.kind = K_ILLEGAL; e.age = 1;
        end else if (lw || sw) begin
            if (lw) e.n_mr = mc; else e.n_mw = mc;
            if (d < 1 || d > MEM_TIMEOUT) begin
                e.kind = K_TIMEOUT; e.age = 2 + MEM_TIMEOUT;
            end else if (sw) begin
                e.kind = K_RETIRE; e.age = 2 + d;
            end else begin
                e.kind = K_RETIRE; e.age = 3 + d; e.n_rw = (dst != 0) ? 1 : 0;
            end
        end else begin
            e.kind = K_RETIRE; e.age = 3; e.n_rw = (dst != 0) ? 1 : 0;
        end
        return e;
    endfunction

    task automatic handshake(input logic [31:0] w);
        int waited = 0;
        @(negedge clock);
        while (!bus.instr_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (!bus.instr_ready) begin
            errors++;
            $display("FAIL instr_ready_wait: actual 0 required 1");
            finish_sim();
        end
        #1;
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        @(posedge clock);
        accepted_seq++;
        #1;
        bus.instr_valid = 1'b0;
        bus.instr       = $urandom();
    endtask

    task automatic issue(input logic [31:0] w, input int d);
        exp_t e;
        e = model(w, d);
        if (e.kind == K_RETIRE) model_cnt = (model_cnt + 1) % (1 << CNT_W);
        e.cnt_after = model_cnt;
        sb.push_back(e);
        handshake(w);
        for (int a = 1; a <= e.age; a++) begin
            bus.mem_ready = (d >= 1 && a == 2 + d);
            @(posedge clock);
            #1;
        end
        bus.mem_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr(input bit alu_only);
        logic [31:0] w;
        int          k;
        w = $urandom();
        k = alu_only ? $urandom_range(0, 6) : $urandom_range(0, 10);
        case (k)
            0: begin w[31:26] = 6'h00; w[5:0] = 6'h20; end
            1: begin w[31:26] = 6'h00; w[5:0] = 6'h22; end
            2: begin w[31:26] = 6'h00; w[5:0] = 6'h24; end
            3: begin w[31:26] = 6'h00; w[5:0] = 6'h25; end
            4: w[31:26] = 6'h08;
            5: w[31:26] = 6'h0C;
            6: w[31:26] = 6'h0D;
            7: w[31:26] = 6'h23;
            8: w[31:26] = 6'h2B;
            9: w[31:26] = 6'h04;
            default: begin w[31:26] = 6'h00; w[5:0] = 6'h2A; end
        endcase
        return w;
    endfunction

    // Monitor: age 1 is the cycle right after the accept edge.
    int   age = 0, seen_seq = 0, n_rw = 0, n_mr = 0, n_mw = 0;
    bit   post_pending = 0;
    int   post_cnt = 0;
    always @(negedge clock) begin
        exp_t e;
        int   act_kind;
        if (accepted_seq != seen_seq) begin
            seen_seq = accepted_seq;
            age = 1; n_rw = 0; n_mr = 0; n_mw = 0;
        end else begin
            age++;
        end
        n_rw += int'(bus.reg_write);
        n_mr += int'(bus.mem_read);
        n_mw += int'(bus.mem_write);
        if (post_pending) begin
            post_pending = 0;
            check("ready_after_end", bus.instr_ready, 1);
            check("retire_count", bus.retire_count, post_cnt);
        end
        checks++;
        if ($countones({bus.reg_write, bus.mem_read, bus.mem_write}) > 1 ||
            $countones({bus.illegal, bus.mem_timeout, bus.retired}) > 1) begin
            errors++;
            $display("FAIL exclusivity: actual rw/mr/mw=%b%b%b il/to/rt=%b%b%b required at most one each",
                     bus.reg_write, bus.mem_read, bus.mem_write, bus.illegal, bus.mem_timeout, bus.retired);
        end
        if (bus.retired || bus.illegal || bus.mem_timeout) begin
            act_kind = bus.retired ? K_RETIRE : (bus.illegal ? K_ILLEGAL : K_TIMEOUT);
            if (sb.size() == 0) begin
                check("unexpected_event", act_kind, -1);
            end else begin
                e = sb.pop_front();
                check("event_kind", act_kind, e.kind);
                check("event_latency", age, e.age);
                if (e.check_fields)
                    check("fields", {bus.rd, bus.rs, bus.rt, bus.immediate, bus.alu_control,
                                     bus.alu_src_imm, bus.imm_zero_ext, bus.mem_to_reg}, e.fields);
                check("reg_write_cycles", n_rw, e.n_rw);
                check("mem_read_cycles", n_mr, e.n_mr);
                check("mem_write_cycles", n_mw, e.n_mw);
                post_pending = 1;
                post_cnt     = e.cnt_after;
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: actual timeout required completion");
        finish_sim();
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.mem_ready   = 1'b0;
        #12;
        check("reset_ready", bus.instr_ready, 1);
        check("reset_outputs", {bus.rd, bus.rs, bus.rt, bus.immediate, bus.alu_control, bus.alu_src_imm,
                                bus.imm_zero_ext, bus.reg_write, bus.mem_to_reg, bus.mem_read,
                                bus.mem_write, bus.illegal, bus.mem_timeout, bus.retired}, 0);
        check("reset_count", bus.retire_count, 0);
        @(negedge clock);
        reset_n = 1'b1;

        issue(32'h0022_1820, 0);          // add $3,$1,$2
        issue(32'h3405_FFFF, 0);          // ori $5,$0,0xFFFF
        issue(32'h2020_0004, 0);          // addi $0,$1,4
        issue(32'h8C24_0008, 3);          // lw $4,8($1), ready in 3rd MEM cycle
        issue(32'hAC24_0008, 1);          // sw, immediate ready
        issue(32'hAC24_0008, 0);          // sw, timeout
        issue(32'hAC24_0008, MEM_TIMEOUT); // sw, ready in final cycle
        issue(32'h1022_0003, 0);          // beq
        issue(32'h0022_182A, 0);          // slt

        // Reset while a lw is waiting in MEM.
        handshake(32'h8C24_0008);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        check("mem_read_before_reset", bus.mem_read, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mem_read_in_reset", bus.mem_read, 0);
        check("ready_in_reset", bus.instr_ready, 1);
        model_cnt = 0;
        check("count_in_reset", bus.retire_count, model_cnt);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < (1 << CNT_W); i++) issue(rand_instr(1'b1), 0);
        @(negedge clock);
        @(negedge clock);
        check("count_wrapped", bus.retire_count, model_cnt);

        for (int i = 0; i < 40; i++) issue(rand_instr(1'b0), $urandom_range(0, MEM_TIMEOUT + 2));

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clock);
        repeat (3) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
        finish_sim();
    end
endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multicycle sequencer for the register-file/ALU/data-memory datapath.
- Accepts one 32-bit MIPS instruction at a time over a valid/ready handshake and decodes it.
- Drives the datapath's rd/rs/rt/immediate/alu_control fields and the register-write and memory strobes, one phase per clock, until the instruction retires.
- Supported subset: add, sub, and, or, addi, andi, ori, lw, sw. Everything else is flagged illegal.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent in MEM waiting for mem_ready before the access is aborted.
- CNT_W, 32: width of retire_count.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr  in  32  instruction word.
- instr_ready  out  1  controller can accept an instruction.
- mem_ready  in  1  data memory access completes this cycle.
- rd  out  5  write-destination register.
- rs  out  5  source register A, instr[25:21].
- rt  out  5  source register B, instr[20:16].
- immediate  out  16  instr[15:0], raw.
- alu_control  out  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR.
- alu_src_imm  out  1  ALU operand B selects immediate.
- imm_zero_ext  out  1  immediate is zero-extended (andi/ori); otherwise sign-extended.
- reg_write  out  1  register-file write strobe.
- mem_to_reg  out  1  write-back data comes from memory.
- mem_read  out  1  data memory read request.
- mem_write  out  1  data memory write request.
- illegal  out  1  unsupported instruction, 1-cycle pulse.
- mem_timeout  out  1  memory access aborted, 1-cycle pulse.
- retired  out  1  instruction completed, 1-cycle pulse.
- retire_count  out  CNT_W  retired instruction count.

Behaviour:
- Reset:
  - Asynchronous and active-low, effective immediately, including mid-instruction.
  - State goes to IDLE; every output goes to 0 except instr_ready=1.
  - Any in-flight access is dropped with no retire.
- States: IDLE, DECODE, EXEC, MEM, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid && instr_ready at an edge: latch instr, go to DECODE.
  - No other state asserts instr_ready.
- Field outputs (rd, rs, rt, immediate, alu_control, alu_src_imm, imm_zero_ext, mem_to_reg):
  - Registered at the DECODE edge.
  - Held until the next accepted instruction.
- Decode:
  - R-type: opcode 0x00, funct 0x20/0x22/0x24/0x25 map to ALU ops 00/01/10/11; rd=instr[15:11].
  - addi 0x08 → 00; andi 0x0C → 10, zero-ext; ori 0x0D → 11, zero-ext.
  - lw 0x23 and sw 0x2B → 00, sign-ext.
  - All I-type instructions: rd=instr[20:16], alu_src_imm=1.
- DECODE:
  - Unsupported opcode or funct: illegal=1 this cycle, next state IDLE, no strobes, no retire.
  - Otherwise next state EXEC.
- EXEC: one cycle, ALU result settles. Next state is MEM for lw/sw, WB otherwise.
- MEM:
  - mem_read (lw) or mem_write (sw) held high for every MEM cycle.
  - A cycle counter clears on MEM entry.
  - mem_ready=1: lw goes to WB; sw sets retired=1 this cycle and goes to IDLE.
  - MEM_TIMEOUT cycles without mem_ready: mem_timeout=1 in the final MEM cycle, go to IDLE, no WB, no retire.
  - mem_ready in that same final cycle wins over the timeout.
- WB:
  - reg_write=1 for exactly one cycle, and retired=1; next state IDLE.
  - If rd==0, reg_write stays 0 but the instruction still retires.
- Latency, accept edge k:
  - ALU op: DECODE k+1, EXEC k+2, WB k+3, instr_ready high k+4.
  - lw with mem_ready on the first MEM cycle: WB k+4, IDLE k+5.
  - sw with mem_ready on the first MEM cycle: retires k+3, IDLE k+4.
- retire_count increments on each retired pulse and wraps modulo 2^CNT_W.
- Strobe exclusivity:
  - mem_read, mem_write and reg_write are never high in the same cycle.
  - illegal, mem_timeout and retired are mutually exclusive.

Test Plan:
- Reset, then add $3,$1,$2 (0x00221820) → rs=1, rt=2, rd=3, alu_control=00; reg_write single cycle at k+3; retired; retire_count=1; instr_ready high at k+4.
- ori $5,$0,0xFFFF (0x3405FFFF) → rd=5, alu_control=11, alu_src_imm=1, imm_zero_ext=1; addi $0,$1,4 → retires with reg_write never asserted.
- lw $4,8($1), mem_ready after 3 MEM cycles → mem_read high exactly 3 cycles; then WB with mem_to_reg=1 and reg_write pulse. sw with immediate mem_ready → mem_write 1 cycle; retired; no reg_write.
- sw with mem_ready held 0 → mem_write for MEM_TIMEOUT cycles; mem_timeout pulse; no retire. Repeat with mem_ready arriving in the final cycle → retired, no mem_timeout.
- Opcode 0x04 (beq), then R-type funct 0x2A (slt) → illegal pulse in the DECODE cycle; back to IDLE at k+2; retire_count unchanged.
- reset_n low during the MEM wait of a lw → mem_read drops asynchronously; IDLE with instr_ready=1; retire_count=0. Then run 2^CNT_W retirements with CNT_W=4 → count wraps to 0.
